// File: rtl/bp_be_aux_wb_sched.sv
// Issue/writeback scheduler for the FP auxiliary pipe, sharing the FP regfile write port with the FMA pipe.
// Latency: an accepted issue reaches writeback exactly latency_p cycles later; the valid/rd/file tags ride a shift chain.
// Backpressure: issue_ready_o drops only for FP-destination ops whose writeback slot is already reserved by an FMA op.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   issue_v_i / issue_ready_o / issue_rd_addr_i / issue_fp_not_int_i : aux issue handshake and destination
//   fma_issue_v_i : FMA op issued this cycle (already granted)
//   flush_i       : kill every in-flight aux op
//   fflags_i / fflags_clear_i / fflags_acc_o : sticky exception-flag accumulator
//   wb_v_o / wb_rd_addr_o / wb_fp_not_int_o  : writeback of the oldest aux op
//   idle_o        : no aux op in flight
//   stall_cnt_o   : saturating stall-cycle counter, present only with BP_BE_AUX_SCHED_PERF_EN defined
module bp_be_aux_wb_sched #(
    parameter int latency_p        = 4,
    parameter int fma_latency_p    = 5,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        issue_v_i,
    output logic                        issue_ready_o,
    input  logic [reg_addr_width_p-1:0] issue_rd_addr_i,
    input  logic                        issue_fp_not_int_i,
    input  logic                        fma_issue_v_i,
    input  logic                        flush_i,
    input  logic [4:0]                  fflags_i,
    input  logic                        fflags_clear_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic                        wb_fp_not_int_o,
    output logic [4:0]                  fflags_acc_o,
    output logic                        idle_o
`ifdef BP_BE_AUX_SCHED_PERF_EN
    ,
    output logic [31:0]                 stall_cnt_o
`endif
);

    // ------------------------------------------------------------------
    // FP write-port reservations made by the FMA pipe.
    // Only slots that an aux issue made now could still collide with are
    // kept: bit 0 means "FP port busy latency_p cycles from now", the top
    // bit means "busy fma_latency_p-1 cycles from now" and is loaded by
    // the FMA issue of the previous cycle. If the FMA pipe is not longer
    // than the aux pipe, no registered reservation can ever land on the
    // aux writeback slot.
    // ------------------------------------------------------------------
    logic fp_busy_reg;

    if (fma_latency_p > latency_p) begin : g_res
        localparam int ResW = fma_latency_p - latency_p;
        logic [ResW-1:0] res_q, res_d;

        always_comb begin
            res_d           = res_q >> 1;
            res_d[ResW-1]   = fma_issue_v_i;
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) res_q <= '0;
            else         res_q <= res_d;
        end

        assign fp_busy_reg = res_q[0];
    end else begin : g_no_res
        assign fp_busy_reg = 1'b0;
    end

    // A same-cycle FMA issue with equal latency would land on the same
    // slot; the FMA op wins the tie.
    logic fp_busy;
    assign fp_busy       = fp_busy_reg | (fma_issue_v_i & (fma_latency_p == latency_p));
    assign issue_ready_o = ~(issue_fp_not_int_i & fp_busy);

    logic accept;
    assign accept = issue_v_i & issue_ready_o;

    // ------------------------------------------------------------------
    // Aux tag chain: stage latency_p-1 drives writeback directly.
    // ------------------------------------------------------------------
    logic [latency_p-1:0]                       v_q, v_d;
    logic [latency_p-1:0]                       fp_q, fp_d;
    logic [latency_p-1:0][reg_addr_width_p-1:0] rd_q, rd_d;

    always_comb begin
        v_d     = '0;
        fp_d    = fp_q;
        rd_d    = rd_q;
        // A flush also swallows an op accepted in the same cycle.
        v_d[0]  = accept & ~flush_i;
        fp_d[0] = issue_fp_not_int_i;
        rd_d[0] = issue_rd_addr_i;
        for (int i = 1; i < latency_p; i++) begin
            v_d[i]  = v_q[i-1] & ~flush_i;
            fp_d[i] = fp_q[i-1];
            rd_d[i] = rd_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q  <= '0;
            fp_q <= '0;
            rd_q <= '0;
        end else begin
            v_q  <= v_d;
            fp_q <= fp_d;
            rd_q <= rd_d;
        end
    end

    assign wb_v_o          = v_q[latency_p-1];
    assign wb_fp_not_int_o = fp_q[latency_p-1];
    assign wb_rd_addr_o    = rd_q[latency_p-1];
    assign idle_o          = ~|v_q;

    // ------------------------------------------------------------------
    // Sticky fflags. A clear coinciding with a commit keeps that commit's
    // flags so they are not lost.
    // ------------------------------------------------------------------
    logic [4:0] fflags_acc_q, fflags_acc_d;

    always_comb begin
        fflags_acc_d = fflags_acc_q;
        if (fflags_clear_i) fflags_acc_d = wb_v_o ? fflags_i : 5'b0;
        else if (wb_v_o)    fflags_acc_d = fflags_acc_q | fflags_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) fflags_acc_q <= '0;
        else         fflags_acc_q <= fflags_acc_d;
    end

    assign fflags_acc_o = fflags_acc_q;

`ifdef BP_BE_AUX_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_v_i & ~issue_ready_o & ~&stall_cnt_q) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bp_be_aux_wb_sched.sv
// Directed bench for bp_be_aux_wb_sched with default parameters (latency 4, FMA latency 5).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Cycle offsets in the checks below are counted from the cycle the relevant issue is presented.
module tb_bp_be_aux_wb_sched;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       issue_v_i;
    logic       issue_ready_o;
    logic [4:0] issue_rd_addr_i;
    logic       issue_fp_not_int_i;
    logic       fma_issue_v_i;
    logic       flush_i;
    logic [4:0] fflags_i;
    logic       fflags_clear_i;
    logic       wb_v_o;
    logic [4:0] wb_rd_addr_o;
    logic       wb_fp_not_int_o;
    logic [4:0] fflags_acc_o;
    logic       idle_o;
`ifdef BP_BE_AUX_SCHED_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    bp_be_aux_wb_sched dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .issue_v_i          (issue_v_i),
        .issue_ready_o      (issue_ready_o),
        .issue_rd_addr_i    (issue_rd_addr_i),
        .issue_fp_not_int_i (issue_fp_not_int_i),
        .fma_issue_v_i      (fma_issue_v_i),
        .flush_i            (flush_i),
        .fflags_i           (fflags_i),
        .fflags_clear_i     (fflags_clear_i),
        .wb_v_o             (wb_v_o),
        .wb_rd_addr_o       (wb_rd_addr_o),
        .wb_fp_not_int_o    (wb_fp_not_int_o),
        .fflags_acc_o       (fflags_acc_o),
        .idle_o             (idle_o)
`ifdef BP_BE_AUX_SCHED_PERF_EN
        ,
        .stall_cnt_o        (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic fp, input logic [4:0] rd);
        issue_v_i          = 1'b1;
        issue_fp_not_int_i = fp;
        issue_rd_addr_i    = rd;
    endtask

    logic seen_wb;

    initial begin
        reset_i            = 1'b1;
        issue_v_i          = 1'b0;
        issue_rd_addr_i    = '0;
        issue_fp_not_int_i = 1'b0;
        fma_issue_v_i      = 1'b0;
        flush_i            = 1'b0;
        fflags_i           = '0;
        fflags_clear_i     = 1'b0;

        // Reset state
        #3;
        check("rst_wb_v",  32'(wb_v_o),        32'd0);
        check("rst_idle",  32'(idle_o),        32'd1);
        check("rst_ready", 32'(issue_ready_o), 32'd1);
        check("rst_acc",   32'(fflags_acc_o),  32'd0);
        #9 reset_i = 1'b0;
        next_cycle();
        next_cycle();

        // Basic FP issue rd=3: writeback exactly 4 cycles later
        next_cycle();
        issue(1'b1, 5'd3);
        #1 check("t1_ready", 32'(issue_ready_o), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            issue_v_i = 1'b0;
            #1;
            check("t1_wb_early", 32'(wb_v_o), 32'd0);
            check("t1_busy",     32'(idle_o), 32'd0);
        end
        next_cycle();
        #1;
        check("t1_wb_v",  32'(wb_v_o),          32'd1);
        check("t1_wb_rd", 32'(wb_rd_addr_o),    32'd3);
        check("t1_wb_fp", 32'(wb_fp_not_int_o), 32'd1);
        check("t1_idle4", 32'(idle_o),          32'd0);
        next_cycle();
        #1;
        check("t1_idle5", 32'(idle_o), 32'd1);
        check("t1_wb_off", 32'(wb_v_o), 32'd0);

        // FMA at A blocks an FP aux op at A+1; accepted at A+2, wb at A+6
        next_cycle();
        fma_issue_v_i = 1'b1;
        next_cycle();
        fma_issue_v_i = 1'b0;
        issue(1'b1, 5'd7);
        #1 check("t2_stall", 32'(issue_ready_o), 32'd0);
        next_cycle();
        #1 check("t2_accept", 32'(issue_ready_o), 32'd1);
        for (int k = 3; k <= 5; k++) begin
            next_cycle();
            issue_v_i = 1'b0;
            #1 check("t2_no_wb", 32'(wb_v_o), 32'd0);
        end
        next_cycle();
        #1;
        check("t2_wb_v",  32'(wb_v_o),       32'd1);
        check("t2_wb_rd", 32'(wb_rd_addr_o), 32'd7);

        // Integer-destination op never conflicts with the FMA slot
        next_cycle();
        fma_issue_v_i = 1'b1;
        next_cycle();
        fma_issue_v_i = 1'b0;
        issue(1'b0, 5'd9);
        #1 check("t3_int_ready", 32'(issue_ready_o), 32'd1);
        next_cycle();
        issue_v_i = 1'b0;
        next_cycle();
        next_cycle();
        #1 check("t3_no_wb", 32'(wb_v_o), 32'd0);
        next_cycle();
        #1;
        check("t3_wb_v",  32'(wb_v_o),          32'd1);
        check("t3_wb_rd", 32'(wb_rd_addr_o),    32'd9);
        check("t3_wb_fp", 32'(wb_fp_not_int_o), 32'd0);

        // Three issues then a flush: nothing writes back
        next_cycle();
        issue(1'b0, 5'd1);
        next_cycle();
        issue(1'b0, 5'd2);
        next_cycle();
        issue(1'b0, 5'd3);
        next_cycle();
        issue_v_i = 1'b0;
        flush_i   = 1'b1;
        #1 check("t4_flush_cyc", 32'(wb_v_o), 32'd0);
        next_cycle();
        flush_i = 1'b0;
        #1;
        check("t4_idle", 32'(idle_o), 32'd1);
        check("t4_wb4",  32'(wb_v_o), 32'd0);
        for (int k = 5; k <= 6; k++) begin
            next_cycle();
            #1 check("t4_wb_late", 32'(wb_v_o), 32'd0);
        end

        // fflags accumulation, clear coincident with a commit (also in a flush cycle)
        next_cycle();
        issue(1'b0, 5'd4);
        next_cycle();
        issue(1'b0, 5'd5);
        next_cycle();
        issue(1'b0, 5'd6);
        next_cycle();
        issue_v_i = 1'b0;
        next_cycle();
        fflags_i = 5'b00001;
        #1 check("t5_wb_rd4", 32'(wb_rd_addr_o), 32'd4);
        next_cycle();
        fflags_i = 5'b10000;
        #1 check("t5_acc1", 32'(fflags_acc_o), 32'h01);
        next_cycle();
        fflags_i       = 5'b00100;
        fflags_clear_i = 1'b1;
        flush_i        = 1'b1;
        #1;
        check("t5_acc2",   32'(fflags_acc_o), 32'h11);
        check("t5_wb_fl",  32'(wb_v_o),       32'd1);
        next_cycle();
        fflags_i       = 5'b01000;
        fflags_clear_i = 1'b0;
        flush_i        = 1'b0;
        #1;
        check("t5_acc_clr", 32'(fflags_acc_o), 32'h04);
        check("t5_wb_gone", 32'(wb_v_o),       32'd0);
        next_cycle();
        fflags_i = 5'b00000;
        #1 check("t5_acc_hold", 32'(fflags_acc_o), 32'h04);

        // Async reset mid-cycle with three ops in flight
        next_cycle();
        issue(1'b1, 5'd10);
        next_cycle();
        issue(1'b1, 5'd11);
        next_cycle();
        issue(1'b1, 5'd12);
        next_cycle();
        issue_v_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        check("t6_wb_v",  32'(wb_v_o),       32'd0);
        check("t6_acc",   32'(fflags_acc_o), 32'd0);
        check("t6_idle",  32'(idle_o),       32'd1);
        next_cycle();
        reset_i = 1'b0;
        seen_wb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            seen_wb = seen_wb | wb_v_o;
        end
        check("t6_no_wb_after", 32'(seen_wb), 32'd0);

        // Seven back-to-back stalls from consecutive FMA issues
        next_cycle();
        fma_issue_v_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            next_cycle();
            fma_issue_v_i = (i < 7);
            issue(1'b1, 5'd13);
            #1 check("t7_stall", 32'(issue_ready_o), 32'd0);
        end
        next_cycle();
        fma_issue_v_i = 1'b0;
        #1 check("t7_accept", 32'(issue_ready_o), 32'd1);
`ifdef BP_BE_AUX_SCHED_PERF_EN
        check("t7_stall_cnt", stall_cnt_o, 32'd7);
`endif
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            issue_v_i = 1'b0;
        end
        next_cycle();
        #1;
        check("t7_wb_v",  32'(wb_v_o),       32'd1);
        check("t7_wb_rd", 32'(wb_rd_addr_o), 32'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_be_aux_wb_sched.md
Name: bp_be_aux_wb_sched

Overview:
- Issue/writeback scheduler for the FP auxiliary pipe (moves, converts, compares, sign-inject, class, min/max).
- The FP register-file write port is shared with the FMA pipe. This block grants aux issue slots so that aux and FMA results never complete in the same cycle on that port.
- Tracks in-flight aux ops (rd, destination file) through a fixed-latency tag chain and kills them on flush.
- Accumulates sticky fflags from committed aux results.

Parameters:
- latency_p, 4, aux pipe latency in cycles (≥1); issue at t → writeback at t+latency_p
- fma_latency_p, 5, FMA pipe latency in cycles (≥1)
- reg_addr_width_p, 5, architectural register address width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- issue_v_i  in  1  aux op presented by dispatcher
- issue_ready_o  out  1  aux op accepted this cycle when issue_v_i & issue_ready_o
- issue_rd_addr_i  in  reg_addr_width_p  destination register
- issue_fp_not_int_i  in  1  1 = FP regfile destination, 0 = integer regfile destination
- fma_issue_v_i  in  1  FMA op issued this cycle; already granted, never stalled by this block
- flush_i  in  1  kill all in-flight aux ops
- fflags_i  in  5  fflags from aux pipe output, valid when wb_v_o
- fflags_clear_i  in  1  clear sticky accumulator
- wb_v_o  out  1  aux result valid for writeback
- wb_rd_addr_o  out  reg_addr_width_p  writeback destination
- wb_fp_not_int_o  out  1  writeback destination file
- fflags_acc_o  out  5  sticky OR of committed aux fflags
- idle_o  out  1  no aux op in flight

Behaviour:
- Reset (async): all tag-chain valids = 0, all FMA reservations = 0, fflags_acc_o = 0.
  - Hence wb_v_o = 0, idle_o = 1, issue_ready_o = 1 unless fma_issue_v_i forces a conflict.
- Aux tag chain: latency_p stages of {v, rd, fp_not_int}.
  - Stage 0 loads on an accepted issue; each stage shifts every cycle.
  - wb_* outputs are the last stage directly (registered). Exactly latency_p cycles from accept to wb_v_o.
- FMA reservation vector: fma_latency_p bits, shifted each cycle.
  - fma_issue_v_i sets the bit meaning "FP port busy at t+fma_latency_p".
- Conflict rule (combinational ready): issue_ready_o = ~(issue_fp_not_int_i & fp_busy_at(t+latency_p)).
  - fp_busy_at(t+latency_p) = registered FMA reservation at that slot, OR (fma_issue_v_i & fma_latency_p==latency_p).
  - When latency_p > fma_latency_p, no FMA reservation can exist at that slot, so ready = 1.
  - Same-cycle tie goes to FMA.
- Integer-destination aux ops never conflict and are always ready.
- issue_ready_o is independent of issue_v_i. Dispatcher holds the op until ready.
- Aux ops cannot conflict with each other: at most one issue per cycle into a fixed latency.
- flush_i: clears all tag-chain valids at the clock edge.
  - The stage-0 load that cycle is also suppressed, even if accepted.
  - wb_v_o is 0 from the next cycle until new issues mature.
  - wb_v_o in the flush cycle itself still commits.
  - FMA reservations are unaffected.
- fflags accumulation at the edge:
  - clear & wb_v_o → acc = fflags_i
  - clear only → 0
  - wb_v_o only → acc | fflags_i
- idle_o = ~|{chain valids}. Combinational from registered state.
- Reset mid-operation: all in-flight ops are dropped with no writeback. FMA reservations are cleared.

Optional Feature:
- Macro: BP_BE_AUX_SCHED_PERF_EN.
- With the macro defined:
  - Adds output stall_cnt_o[31:0], counting cycles with issue_v_i & ~issue_ready_o.
  - Saturates at 2^32-1.
  - Reset to 0 asynchronously; not affected by flush.
- Without it: no port, no counter logic.

Test Plan:
- Reset, then issue FP op rd=3 at cycle 10 → issue_ready_o=1; wb_v_o=1, wb_rd_addr_o=3, wb_fp_not_int_o=1 exactly at cycle 14; idle_o=0 for cycles 11–14, 1 at cycle 15.
- fma_issue_v_i at cycle 10, FP aux issue_v_i held from cycle 11 (fma_latency_p=5, latency_p=4) → ready=0 at cycle 11, accepted at 12, wb_v_o at 16, no wb at 15.
- Same setup but issue_fp_not_int_i=0 at cycle 11 → accepted at 11, wb_v_o at 15.
- Issue at cycles 10, 11, 12; flush_i at cycle 13 → wb_v_o=0 for cycles 14–16; idle_o=1 at cycle 14.
- Commits with fflags_i=5'b00001 then 5'b10000 → fflags_acc_o=5'b10001; fflags_clear_i coincident with commit of 5'b00100 → 5'b00100.
- Assert reset_i asynchronously mid-clock with 3 ops in flight → wb_v_o=0 and fflags_acc_o=0 immediately; no writeback after release. With BP_BE_AUX_SCHED_PERF_EN, after 7 stall cycles stall_cnt_o=7.
